// File: rtl/fetch_sched_pkg.sv
// Shared definitions for the two-thread fetch scheduler: thread count, PC
// increment, per-thread state encoding and PC alignment helper.
package fetch_sched_pkg;

  localparam int          NUM_THREADS = 2;
  localparam logic [63:0] PC_STEP     = 64'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } thr_state_e;

  // Fetch addresses are word aligned; redirect targets drop their low two bits.
  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return pc & ~64'd3;
  endfunction

endpackage

// File: rtl/fetch_scheduler_rr_arb2.sv
// Two-request round-robin arbiter with a one-hot grant; on a tie the request
// not granted most recently wins. The pointer moves only when a grant is made.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last;  // index of the most recently granted requester

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last <= 1'b1;
    else if (|gnt) last <= gnt[1];
  end

endmodule

// File: rtl/fetch_scheduler.sv
// Two-thread instruction fetch scheduler: per-thread IDLE/RUN/FLUSH FSMs,
// round-robin fetch issue, redirects with flush pulses. Optional per-thread
// grant counters are built when FETCH_SCHED_PERF_EN is defined.
module fetch_scheduler
  import fetch_sched_pkg::*;
#(
  parameter logic [63:0] RESET_PC0 = 64'h0000_0000_0000_0000,
  parameter logic [63:0] RESET_PC1 = 64'h0000_0000_0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  thr_en,
  input  logic [1:0]  q_full,
  input  logic [1:0]  q_afull,
  input  logic        redirect_valid,
  input  logic        redirect_tid,
  input  logic [63:0] redirect_pc,
  output logic        fetch_valid,
  output logic        fetch_tid,
  output logic [63:0] fetch_pc,
  output logic [1:0]  flush
`ifdef FETCH_SCHED_PERF_EN
  ,
  output logic [31:0] grant_cnt0,
  output logic [31:0] grant_cnt1
`endif
);

  thr_state_e  state [NUM_THREADS];
  logic [63:0] pc    [NUM_THREADS];
  logic [1:0]  redir;
  logic [1:0]  elig;
  logic [1:0]  gnt;

  // A thread that just issued into a queue with one free slot sits out a
  // cycle so the queue cannot overflow before q_full catches up.
  always_comb begin
    redir = 2'b00;
    elig  = 2'b00;
    for (int t = 0; t < NUM_THREADS; t++) begin
      redir[t] = redirect_valid && (redirect_tid == 1'(t));
      elig[t]  = (state[t] == RUN) && thr_en[t] && !q_full[t] && !redir[t] &&
                 !(fetch_valid && (fetch_tid == 1'(t)) && q_afull[t]);
    end
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (elig),
    .gnt   (gnt)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the PC array is two architectural registers, not a RAM, so it
      // takes the asynchronous reset like any other state.
      for (int t = 0; t < NUM_THREADS; t++) state[t] <= IDLE;
      pc[0]       <= RESET_PC0;
      pc[1]       <= RESET_PC1;
      fetch_valid <= 1'b0;
      fetch_tid   <= 1'b0;
      fetch_pc    <= '0;
      flush       <= 2'b00;
    end else begin
      fetch_valid <= |gnt;
      if (|gnt) begin
        fetch_tid <= gnt[1];
        fetch_pc  <= pc[gnt[1]];
      end
      for (int t = 0; t < NUM_THREADS; t++) begin
        flush[t] <= redir[t] && (state[t] != IDLE);
        if (redir[t])    pc[t] <= align_pc(redirect_pc);
        else if (gnt[t]) pc[t] <= pc[t] + PC_STEP;
        case (state[t])
          IDLE:    if (!redir[t] && thr_en[t]) state[t] <= RUN;
          RUN:     if (redir[t]) state[t] <= FLUSH;
                   else if (!thr_en[t]) state[t] <= IDLE;
          FLUSH:   if (redir[t]) state[t] <= FLUSH;
                   else state[t] <= thr_en[t] ? RUN : IDLE;
          default: state[t] <= IDLE;
        endcase
      end
    end
  end

`ifdef FETCH_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (fetch_valid) begin
      if (fetch_tid) grant_cnt1 <= grant_cnt1 + 32'd1;
      else           grant_cnt0 <= grant_cnt0 + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_scheduler.sv
// Self-checking bench for fetch_scheduler: a thread-level reference model is
// compared every cycle, plus directed literal expectations.
module tb_fetch_scheduler;

  localparam logic [63:0] RPC0 = 64'h0000_0000_0000_0000;
  localparam logic [63:0] RPC1 = 64'h0000_0000_0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  thr_en, q_full, q_afull;
  logic        redirect_valid, redirect_tid;
  logic [63:0] redirect_pc;
  logic        fetch_valid, fetch_tid;
  logic [63:0] fetch_pc;
  logic [1:0]  flush;
`ifdef FETCH_SCHED_PERF_EN
  logic [31:0] grant_cnt0, grant_cnt1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .thr_en         (thr_en),
    .q_full         (q_full),
    .q_afull        (q_afull),
    .redirect_valid (redirect_valid),
    .redirect_tid   (redirect_tid),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .fetch_tid      (fetch_tid),
    .fetch_pc       (fetch_pc),
    .flush          (flush)
`ifdef FETCH_SCHED_PERF_EN
    ,
    .grant_cnt0     (grant_cnt0),
    .grant_cnt1     (grant_cnt1)
`endif
  );

  // Reference model: a thread runs next cycle when enabled and not redirected;
  // it is "busy" (flushable) while enabled or while serving a flush cycle.
  logic [63:0] m_pc [2];
  logic [1:0]  m_run, m_busy, m_redir, m_elig;
  int          m_last, m_gnt;
  logic        exp_valid, exp_tid;
  logic [63:0] exp_pc;
  logic [1:0]  exp_flush;
  logic [31:0] m_cnt [2];

  always_comb begin
    m_redir = 2'b00;
    m_elig  = 2'b00;
    m_gnt   = -1;
    for (int t = 0; t < 2; t++) begin
      m_redir[t] = redirect_valid && (int'(redirect_tid) == t);
      m_elig[t]  = m_run[t] && thr_en[t] && !q_full[t] && !m_redir[t] &&
                   !(exp_valid && (int'(exp_tid) == t) && q_afull[t]);
    end
    if (m_elig == 2'b11) m_gnt = 1 - m_last;
    else if (m_elig[0])  m_gnt = 0;
    else if (m_elig[1])  m_gnt = 1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc[0]   <= RPC0;
      m_pc[1]   <= RPC1;
      m_run     <= 2'b00;
      m_busy    <= 2'b00;
      m_last    <= 1;
      exp_valid <= 1'b0;
      exp_tid   <= 1'b0;
      exp_pc    <= '0;
      exp_flush <= 2'b00;
      m_cnt[0]  <= '0;
      m_cnt[1]  <= '0;
    end else begin
      if (exp_valid) m_cnt[exp_tid] <= m_cnt[exp_tid] + 32'd1;
      exp_valid <= (m_gnt >= 0);
      if (m_gnt >= 0) begin
        exp_tid <= (m_gnt == 1);
        exp_pc  <= m_pc[m_gnt];
        m_last  <= m_gnt;
      end
      for (int t = 0; t < 2; t++) begin
        if (m_redir[t])     m_pc[t] <= redirect_pc & ~64'd3;
        else if (m_gnt == t) m_pc[t] <= m_pc[t] + 64'd4;
        exp_flush[t] <= m_redir[t] && m_busy[t];
        m_busy[t]    <= m_redir[t] ? m_busy[t] : thr_en[t];
        m_run[t]     <= thr_en[t] && !m_redir[t];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: wait for the falling edge, then compare every output to the model.
  task automatic tick();
    @(negedge clk);
    check("model_valid", 64'(fetch_valid), 64'(exp_valid));
    check("model_tid",   64'(fetch_tid),   64'(exp_tid));
    check("model_pc",    fetch_pc,         exp_pc);
    check("model_flush", 64'(flush),       64'(exp_flush));
`ifdef FETCH_SCHED_PERF_EN
    check("model_cnt0", 64'(grant_cnt0), 64'(m_cnt[0]));
    check("model_cnt1", 64'(grant_cnt1), 64'(m_cnt[1]));
`endif
  endtask

  task automatic expect_fetch(input string name, input logic tid, input logic [63:0] pc);
    tick();
    check({name, "_valid"}, 64'(fetch_valid), 64'd1);
    check({name, "_tid"},   64'(fetch_tid),   64'(tid));
    check({name, "_pc"},    fetch_pc,         pc);
  endtask

  task automatic expect_idle(input string name);
    tick();
    check({name, "_valid"}, 64'(fetch_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; thr_en = 2'b00; q_full = 2'b00; q_afull = 2'b00;
    redirect_valid = 1'b0; redirect_tid = 1'b0; redirect_pc = '0;
    @(posedge clk);
    tick();
    check("rst_valid", 64'(fetch_valid), 64'd0);
    check("rst_pc",    fetch_pc,         64'd0);
    check("rst_flush", 64'(flush),       64'd0);

    // Both threads on, queues empty: alternation starting with thread 0.
    rst_n = 1'b1; thr_en = 2'b11;
    expect_idle("startup");
    expect_fetch("rr0", 1'b0, 64'h0);
    expect_fetch("rr1", 1'b1, 64'h1000);
    expect_fetch("rr2", 1'b0, 64'h4);
    expect_fetch("rr3", 1'b1, 64'h1004);

    // Thread 1 queue full: thread 0 issues back to back.
    q_full = 2'b10;
    expect_fetch("full0", 1'b0, 64'h8);
    expect_fetch("full1", 1'b0, 64'hC);
    expect_fetch("full2", 1'b0, 64'h10);
    q_full = 2'b00;
    expect_fetch("resume1", 1'b1, 64'h1008);
    expect_fetch("resume0", 1'b0, 64'h14);

    // Redirect thread 1 on the cycle it would win.
    redirect_valid = 1'b1; redirect_tid = 1'b1; redirect_pc = 64'h2003;
    expect_fetch("redir_t0", 1'b0, 64'h18);
    check("redir_flush", 64'(flush), 64'h2);
    redirect_valid = 1'b0;
    expect_fetch("flushcyc_t0", 1'b0, 64'h1C);
    check("flush_drop", 64'(flush), 64'h0);
    expect_fetch("redir_t1", 1'b1, 64'h2000);

    // Almost-full back-off with thread 1 disabled.
    thr_en = 2'b01; q_afull = 2'b01;
    expect_fetch("afull_g", 1'b0, 64'h20);
    expect_idle("afull_gap");
    check("afull_hold_pc", fetch_pc, 64'h20);
    q_afull = 2'b00;
    expect_fetch("afull_res", 1'b0, 64'h24);

    // Wrap at the top of the address space (target low bits dropped).
    redirect_valid = 1'b1; redirect_tid = 1'b0; redirect_pc = '1;
    expect_idle("wrap_redir");
    check("wrap_flush", 64'(flush), 64'h1);
    redirect_valid = 1'b0;
    expect_idle("wrap_flushcyc");
    expect_fetch("wrap_top", 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
    expect_fetch("wrap_zero", 1'b0, 64'h0);

    // Disable retains the PC; re-enable resumes from it.
    thr_en = 2'b00;
    expect_idle("dis0");
    expect_idle("dis1");
    thr_en = 2'b01;
    expect_idle("reen");
    expect_fetch("reen_pc", 1'b0, 64'h4);

    // Redirect of an idle thread: PC loads, no flush pulse.
    redirect_valid = 1'b1; redirect_tid = 1'b1; redirect_pc = 64'h3000;
    expect_fetch("idle_redir_t0", 1'b0, 64'h8);
    check("idle_redir_flush", 64'(flush), 64'h0);
    redirect_valid = 1'b0; thr_en = 2'b11;
    expect_fetch("idle_en_t0", 1'b0, 64'hC);
    expect_fetch("idle_en_t1", 1'b1, 64'h3000);

    // Asynchronous reset mid-cycle with a redirect pending.
    redirect_valid = 1'b1; redirect_tid = 1'b0; redirect_pc = 64'h5000;
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 64'(fetch_valid), 64'd0);
    check("async_pc",    fetch_pc,         64'd0);
    check("async_tid",   64'(fetch_tid),   64'd0);
`ifdef FETCH_SCHED_PERF_EN
    check("async_cnt0", 64'(grant_cnt0), 64'd0);
    check("async_cnt1", 64'(grant_cnt1), 64'd0);
`endif
    tick();
    rst_n = 1'b1; redirect_valid = 1'b0;
    expect_idle("post_rst");
    check("post_rst_flush", 64'(flush), 64'h0);
    expect_fetch("post_rst_t0", 1'b0, 64'h0);
    expect_fetch("post_rst_t1", 1'b1, 64'h1000);

`ifdef FETCH_SCHED_PERF_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_idle("perf_start");
    repeat (11) tick();
    check("perf_cnt0", 64'(grant_cnt0), 64'd5);
    check("perf_cnt1", 64'(grant_cnt1), 64'd5);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
